// File: rtl/bus_arbiter.sv
// bus_arbiter: single-port RAM arbiter between the CPU microcode path and a
// DMA loader/debug port. Every access takes one IDLE arbitration cycle plus
// one grant cycle. CPU wins ties unless DMA has been starved STARVE_MAX times.
module bus_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [11:0] dma_addr,
    input  logic [3:0]  dma_wdata,
    output logic        dma_gnt,
    output logic [3:0]  dma_rdata,
    output logic        dma_rvalid,
    input  logic [3:0]  bus_data,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic        oe_dma
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_ACC = 2'd1;
    localparam logic [1:0] DMA_ACC = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [3:0] starve_cnt;
    logic       dma_rd_done;

    // dma_wdata reaches the bus through the external driver gated by oe_dma
    logic unused_wdata;
    assign unused_wdata = ^dma_wdata;

    assign dma_rd_done = (state == DMA_ACC) && !dma_we;

    // Arbitration: requests are only sampled in IDLE; grant states last one cycle
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (cpu_req && dma_req)
                    next_state = (starve_cnt == STARVE_LIM) ? DMA_ACC : CPU_ACC;
                else if (cpu_req)
                    next_state = CPU_ACC;
                else if (dma_req)
                    next_state = DMA_ACC;
                else
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Count CPU grants taken while DMA waits; cleared once DMA is served or idle
    always_ff @(posedge clk) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!dma_req)
            starve_cnt <= '0;
        else if (state == IDLE && next_state == DMA_ACC)
            starve_cnt <= '0;
        else if (state == IDLE && next_state == CPU_ACC && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // Capture the bus nibble at the end of a DMA read grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_rd_done;
            if (dma_rd_done)
                dma_rdata <= bus_data;
        end
    end

    // Decode RAM control and grants from the current state
    always_comb begin
        cpu_gnt  = 1'b0;
        dma_gnt  = 1'b0;
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        oe_dma   = 1'b0;
        case (state)
            CPU_ACC: begin
                cpu_gnt  = 1'b1;
                ram_cs   = 1'b1;
                ram_we   = cpu_we;
                ram_addr = cpu_addr;
            end
            DMA_ACC: begin
                dma_gnt  = 1'b1;
                ram_cs   = 1'b1;
                ram_we   = dma_we;
                ram_addr = dma_addr;
                oe_dma   = dma_we;
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req && !cpu_gnt;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive CPU grants issued while dma_req is pending; range 1..15.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 cpu_req  in  1  CPU requests one RAM access (driven from microcode cs bit).
REQ-005 cpu_we  in  1  CPU access type: 1 write, 0 read.
REQ-006 cpu_addr  in  12  CPU RAM address ({operand, data}).
REQ-007 cpu_gnt  out  1  CPU access granted this cycle.
REQ-008 cpu_stall  out  1  hold Phase/PC/Fetch; = cpu_req AND NOT cpu_gnt, combinational.
REQ-009 dma_req  in  1  loader/debug port requests one RAM access.
REQ-010 dma_we  in  1  DMA access type: 1 write, 0 read.
REQ-011 dma_addr  in  12  DMA RAM address.
REQ-012 dma_wdata  in  4  DMA write nibble.
REQ-013 dma_gnt  out  1  DMA access granted this cycle.
REQ-014 dma_rdata  out  4  last DMA read nibble, registered.
REQ-015 dma_rvalid  out  1  one-cycle pulse: dma_rdata updated.
REQ-016 bus_data  in  4  shared 4-bit tri-state data bus, sampled for DMA reads.
REQ-017 ram_cs  out  1  RAM chip select.
REQ-018 ram_we  out  1  RAM write enable.
REQ-019 ram_addr  out  12  RAM address, muxed from granted requester; 0 when idle.
REQ-020 oe_dma  out  1  enables busDriver placing dma_wdata on the bus.

Function
REQ-021 FSM states SHALL be IDLE, CPU_ACC, DMA_ACC; every access = IDLE arbitration cycle + one grant cycle, no back-to-back grants.
REQ-022 IDLE: at rising edge, sampled requests select next state: none -> IDLE; cpu_req only -> CPU_ACC; dma_req only -> DMA_ACC; both -> CPU_ACC unless starve_cnt = STARVE_MAX, then DMA_ACC.
REQ-023 CPU_ACC and DMA_ACC SHALL last exactly one cycle and always return to IDLE.
REQ-024 CPU_ACC: cpu_gnt=1, ram_cs=1, ram_we=cpu_we, ram_addr=cpu_addr, oe_dma=0.
REQ-025 DMA_ACC: dma_gnt=1, ram_cs=1, ram_we=dma_we, ram_addr=dma_addr, oe_dma=dma_we.
REQ-026 IDLE: cpu_gnt=dma_gnt=ram_cs=ram_we=oe_dma=0, ram_addr=0.
REQ-027 Handshake: requester holds req, we, addr, wdata stable until cycle with gnt=1 and deasserts req by next rising edge; req high in IDLE following a grant is a new request.
REQ-028 Request dropped before grant SHALL be ignored; no access, no error.
REQ-029 starve_cnt (4 bits) SHALL increment on each entry to CPU_ACC while dma_req=1, saturating at STARVE_MAX; clear on entry to DMA_ACC or any edge with dma_req=0.
REQ-030 DMA read: at rising edge ending DMA_ACC with dma_we=0, dma_rdata <= bus_data; dma_rvalid=1 for the following cycle only.
REQ-031 dma_rdata SHALL hold its value until next DMA read capture; DMA writes and CPU accesses do not alter it.
REQ-032 gnt outputs SHALL be mutually exclusive every cycle; ram_cs=1 only when one gnt=1.

Reset
REQ-033 reset=0 at rising edge: state IDLE, starve_cnt=0, dma_rdata=0, dma_rvalid=0; all registered outputs 0 next cycle.
REQ-034 reset asserted during CPU_ACC/DMA_ACC SHALL abort: no dma_rdata capture, gnt low next cycle, request must be reissued.
REQ-035 reset has priority over all other inputs.

Verification
REQ-036 cpu_req=1, we=1, addr=0x123, dma idle -> cpu_gnt high cycle 2, ram_cs=1, ram_we=1, ram_addr=0x123, cpu_stall=1 cycle 1 only.
REQ-037 dma_req=1, we=0, addr=0x0A5, bus_data=4'h9 -> dma_gnt cycle 2, oe_dma=0, dma_rdata=9 and dma_rvalid=1 cycle 3.
REQ-038 cpu_req and dma_req both held (requests reissued each IDLE), STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,DMA, repeat.
REQ-039 dma write 4'hC to 0xFFF -> DMA_ACC: ram_we=1, oe_dma=1, ram_addr=0xFFF; dma_rdata unchanged.
REQ-040 reset=0 during DMA_ACC read -> next cycle all outputs 0, dma_rvalid stays 0, dma_rdata=0.
REQ-041 cpu_req pulsed 1 cycle in non-IDLE state then dropped -> no cpu_gnt, no ram_cs.
